// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the copy-engine state type.
// Imported by the block-copy master and its testbench.
package ahb_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DATA    = 4'b0011;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_DATA,
      FIN
   } copy_state_t;

endpackage

// File: rtl/ahb_copy_master_if.sv
// AHB-Lite bus bundle between the copy master and the system bus mux.
interface ahb_copy_master_if;

   logic [31:0]      HADDR;
   ahb_pkg::htrans_t HTRANS;
   logic             HWRITE;
   logic [2:0]       HSIZE;
   logic [2:0]       HBURST;
   logic [3:0]       HPROT;
   logic             HMASTLOCK;
   logic [31:0]      HWDATA;
   logic             HREADY;
   logic [31:0]      HRDATA;
   logic             HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HREADY, HRDATA, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HREADY, HRDATA, HRESP
   );

endinterface

// File: rtl/ahb_copy_master.sv
// AHB-Lite master copying a block of words from src to dst, one word at a time,
// with each write data phase overlapped by the next read address phase.
module ahb_copy_master
   import ahb_pkg::*;
#(
   parameter int LEN_W = 9
)
(
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] length,
   output logic             busy,
   output logic             done,
   output logic             error,
   ahb_copy_master_if.master ahb
);

   copy_state_t      state_q, state_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [31:0]      buf_q, buf_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             error_q, error_d;
   logic [31:0]      src_next;
   logic             more_words;

   assign src_next   = src_q + 32'd4;
   assign more_words = (count_q > LEN_W'(1));

   assign ahb.HSIZE     = HSIZE_WORD;
   assign ahb.HBURST    = HBURST_SINGLE;
   assign ahb.HPROT     = HPROT_DATA;
   assign ahb.HMASTLOCK = 1'b0;
   assign ahb.HWDATA    = buf_q;

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == FIN);
   assign error = error_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         buf_q   <= '0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         buf_q   <= buf_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   // An ERROR response cancels the overlapped read address in its first cycle,
   // hence HTRANS in WR_DATA also depends on HRESP.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      buf_d      = buf_q;
      count_d    = count_q;
      error_d    = error_q;
      ahb.HTRANS = TRANS_IDLE;
      ahb.HADDR  = src_q;
      ahb.HWRITE = 1'b0;

      case (state_q)
         IDLE: begin
            ahb.HADDR = '0;
            if (start) begin
               src_d   = src_addr & 32'hFFFF_FFFC;
               dst_d   = dst_addr & 32'hFFFF_FFFC;
               count_d = length;
               error_d = 1'b0;
               state_d = (length == '0) ? FIN : RD_ADDR;
            end
         end
         RD_ADDR: begin
            ahb.HTRANS = TRANS_NONSEQ;
            if (ahb.HREADY) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (ahb.HREADY) begin
               if (ahb.HRESP == HRESP_ERROR) begin
                  error_d = 1'b1;
                  state_d = FIN;
               end else begin
                  buf_d   = ahb.HRDATA;
                  state_d = WR_ADDR;
               end
            end
         end
         WR_ADDR: begin
            ahb.HTRANS = TRANS_NONSEQ;
            ahb.HWRITE = 1'b1;
            ahb.HADDR  = dst_q;
            if (ahb.HREADY) state_d = WR_DATA;
         end
         WR_DATA: begin
            ahb.HADDR = src_next;
            if (more_words && ahb.HRESP == HRESP_OKAY) ahb.HTRANS = TRANS_NONSEQ;
            if (ahb.HREADY) begin
               if (ahb.HRESP == HRESP_ERROR) begin
                  error_d = 1'b1;
                  state_d = FIN;
               end else begin
                  src_d   = src_next;
                  dst_d   = dst_q + 32'd4;
                  count_d = count_q - LEN_W'(1);
                  state_d = more_words ? RD_DATA : FIN;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ahb_copy_master.sv
// Directed bench for ahb_copy_master with a behavioural AHB-Lite slave
// (ROM pattern on reads, write-capturing RAM, wait-state and error injection).
module tb_ahb_copy_master;
   import ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [8:0]  length;
   logic        busy;
   logic        done;
   logic        error;

   int tests_run = 0;
   int tests_failed = 0;

   ahb_copy_master_if bus();

   ahb_copy_master #(.LEN_W(9)) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .length   (length),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .ahb      (bus)
   );

   always #5 HCLK = ~HCLK;

   // Slave model state
   logic        dp_valid;
   logic        dp_write;
   logic [31:0] dp_addr;
   int          wait_left;
   int          err_phase;
   int          wr_issued;
   int          n_addr;
   int          wait_cfg = 0;
   int          err_write_idx = 0;
   logic [31:0] mem [256];
   bit          wr_flag [256];
   logic [31:0] addr_log [64];
   logic        write_log [64];

   // Monitor counters
   int          done_cnt;
   int          busy_cnt;
   int          nonidle_cnt;
   int          stab_err;
   logic        prev_hready;
   logic [1:0]  prev_htrans;
   logic [31:0] prev_haddr;
   logic        prev_hwrite;
   logic [31:0] prev_hwdata;
   logic        prev_wphase;

   function automatic logic [7:0] mem_idx(input logic [31:0] a);
      return {a[29], a[8:2]};
   endfunction

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {8'h00, a[31:24], 16'h00A0} + {28'h0, a[5:2]};
   endfunction

   always_comb begin
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = '0;
      if (dp_valid) begin
         if (wait_left > 0) begin
            bus.HREADY = 1'b0;
         end else if (err_phase == 1) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = 1'b1;
         end else if (err_phase == 2) begin
            bus.HRESP  = 1'b1;
         end
         if (!dp_write) bus.HRDATA = rom_word(dp_addr);
      end
   end

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid  <= 1'b0;
         dp_write  <= 1'b0;
         dp_addr   <= '0;
         wait_left <= 0;
         err_phase <= 0;
      end else if (bus.HREADY) begin
         if (dp_valid && dp_write && !bus.HRESP) begin
            mem[mem_idx(dp_addr)]     <= bus.HWDATA;
            wr_flag[mem_idx(dp_addr)] <= 1'b1;
         end
         if (bus.HTRANS == TRANS_NONSEQ) begin
            dp_valid  <= 1'b1;
            dp_addr   <= bus.HADDR;
            dp_write  <= bus.HWRITE;
            wait_left <= wait_cfg;
            err_phase <= (bus.HWRITE && err_write_idx != 0 &&
                          wr_issued + 1 == err_write_idx) ? 1 : 0;
            if (bus.HWRITE) wr_issued <= wr_issued + 1;
            if (n_addr < 64) begin
               addr_log[n_addr]  <= bus.HADDR;
               write_log[n_addr] <= bus.HWRITE;
            end
            n_addr <= n_addr + 1;
         end else begin
            dp_valid  <= 1'b0;
            err_phase <= 0;
         end
      end else begin
         if (wait_left > 0) wait_left <= wait_left - 1;
         else if (err_phase == 1) err_phase <= 2;
      end
   end

   // Stalled address/control and write data must hold until HREADY returns.
   always @(negedge HCLK) begin
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (bus.HTRANS != TRANS_IDLE) nonidle_cnt <= nonidle_cnt + 1;
      if (HRESETn === 1'b1 && prev_hready === 1'b0) begin
         if (prev_htrans == 2'b10 && !bus.HRESP &&
             (bus.HTRANS != prev_htrans || bus.HADDR != prev_haddr ||
              bus.HWRITE != prev_hwrite))
            stab_err <= stab_err + 1;
         if (prev_wphase && bus.HWDATA != prev_hwdata)
            stab_err <= stab_err + 1;
      end
      prev_hready <= (HRESETn === 1'b1) ? bus.HREADY : 1'b1;
      prev_htrans <= bus.HTRANS;
      prev_haddr  <= bus.HADDR;
      prev_hwrite <= bus.HWRITE;
      prev_hwdata <= bus.HWDATA;
      prev_wphase <= dp_valid && dp_write;
   end

   task automatic step();
      @(negedge HCLK);
      #1;
   endtask

   task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                             input logic [8:0] n);
      src_addr = s;
      dst_addr = d;
      length   = n;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   task automatic wait_done(input int c_start, input int limit, output int c);
      c = c_start;
      while (done !== 1'b1 && c < limit) begin
         step();
         c++;
      end
   endtask

   task automatic test_reset();
      step();
      step();
      tests_run++;
      if ({busy, done, error} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: busy/done/error got %b expected 000", {busy, done, error});
      end
      tests_run++;
      if (bus.HTRANS !== TRANS_IDLE || bus.HWRITE !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl: HTRANS/HWRITE got %b/%b expected 00/0", bus.HTRANS, bus.HWRITE);
      end
      tests_run++;
      if (bus.HADDR !== 32'h0 || bus.HWDATA !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_bus: HADDR/HWDATA got %h/%h expected 0/0", bus.HADDR, bus.HWDATA);
      end
      tests_run++;
      if ({bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== {3'b010, 3'b000, 4'b0011, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL const_ctrl: got %b expected %b",
                  {bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK}, {3'b010, 3'b000, 4'b0011, 1'b0});
      end
      HRESETn = 1'b1;
      step();
   endtask

   task automatic test_zero_wait();
      int c, base, d0;
      logic [31:0] exp_a [6];
      logic exp_w;
      exp_a = '{32'h100, 32'h2000_0000, 32'h104, 32'h2000_0004, 32'h108, 32'h2000_0008};
      base = n_addr;
      d0   = done_cnt;
      start_copy(32'h0000_0100, 32'h2000_0000, 9'd3);
      wait_done(1, 40, c);
      tests_run++;
      if (c != 11) begin
         tests_failed++;
         $display("[TB] FAIL zw_done_cycle: got %0d expected 11", c);
      end
      tests_run++;
      if (error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL zw_error: got %b expected 0", error);
      end
      step();
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || done_cnt - d0 != 1) begin
         tests_failed++;
         $display("[TB] FAIL zw_finish: busy %b done %b pulses %0d expected 0 0 1", busy, done, done_cnt - d0);
      end
      tests_run++;
      if (n_addr - base != 6) begin
         tests_failed++;
         $display("[TB] FAIL zw_addr_count: got %0d expected 6", n_addr - base);
      end
      for (int i = 0; i < 6; i++) begin
         exp_w = (i % 2 == 1);
         tests_run++;
         if (addr_log[base+i] !== exp_a[i] || write_log[base+i] !== exp_w) begin
            tests_failed++;
            $display("[TB] FAIL zw_addr_%0d: got %h/%b expected %h/%b", i,
                     addr_log[base+i], write_log[base+i], exp_a[i], exp_w);
         end
      end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (mem[128+i] !== 32'hA0 + i) begin
            tests_failed++;
            $display("[TB] FAIL zw_data_%0d: got %h expected %h", i, mem[128+i], 32'hA0 + i);
         end
      end
   endtask

   task automatic test_wait_states();
      int c, s0;
      s0 = stab_err;
      wait_cfg = 2;
      start_copy(32'h0000_0110, 32'h2000_0020, 9'd2);
      repeat (6) step();
      tests_run++;
      if (bus.HREADY !== 1'b0 || bus.HTRANS !== TRANS_NONSEQ || bus.HADDR !== 32'h114 ||
          bus.HWDATA !== 32'hA4) begin
         tests_failed++;
         $display("[TB] FAIL ws_stall_bus: HREADY %b HTRANS %b HADDR %h HWDATA %h expected 0 10 114 a4",
                  bus.HREADY, bus.HTRANS, bus.HADDR, bus.HWDATA);
      end
      wait_done(7, 60, c);
      tests_run++;
      if (c != 16) begin
         tests_failed++;
         $display("[TB] FAIL ws_done_cycle: got %0d expected 16", c);
      end
      wait_cfg = 0;
      step();
      tests_run++;
      if (stab_err != s0) begin
         tests_failed++;
         $display("[TB] FAIL ws_stability: got %0d violations expected 0", stab_err - s0);
      end
      tests_run++;
      if (mem[136] !== 32'hA4 || mem[137] !== 32'hA5) begin
         tests_failed++;
         $display("[TB] FAIL ws_data: got %h %h expected a4 a5", mem[136], mem[137]);
      end
   endtask

   task automatic test_length_zero();
      int b0, n0, d0;
      b0 = busy_cnt;
      n0 = nonidle_cnt;
      d0 = done_cnt;
      start_copy(32'h0000_0100, 32'h2000_0000, 9'd0);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL len0_fin: done %b busy %b expected 1 1", done, busy);
      end
      step();
      step();
      tests_run++;
      if (busy_cnt - b0 != 1 || done_cnt - d0 != 1 || nonidle_cnt != n0) begin
         tests_failed++;
         $display("[TB] FAIL len0_counts: busy %0d done %0d nonidle %0d expected 1 1 0",
                  busy_cnt - b0, done_cnt - d0, nonidle_cnt - n0);
      end
   endtask

   task automatic test_error_write();
      int c, base;
      base = n_addr;
      err_write_idx = wr_issued + 2;
      start_copy(32'h0000_0100, 32'h2000_0040, 9'd4);
      repeat (6) step();
      tests_run++;
      if (bus.HTRANS !== TRANS_IDLE) begin
         tests_failed++;
         $display("[TB] FAIL err_htrans_cancel: got %b expected 00", bus.HTRANS);
      end
      wait_done(7, 40, c);
      tests_run++;
      if (c != 9 || error !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL err_done: cycle %0d error %b expected 9 1", c, error);
      end
      err_write_idx = 0;
      step();
      tests_run++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL err_sticky: error %b busy %b expected 1 0", error, busy);
      end
      tests_run++;
      if (mem[144] !== 32'hA0 || wr_flag[145] !== 1'b0 || n_addr - base != 4) begin
         tests_failed++;
         $display("[TB] FAIL err_written: word0 %h word1_written %b addrs %0d expected a0 0 4",
                  mem[144], wr_flag[145], n_addr - base);
      end
   endtask

   task automatic test_back_to_back();
      int c, base;
      base = n_addr;
      start_copy(32'hFFFF_FFFC, 32'h2000_0060, 9'd2);
      tests_run++;
      if (error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_error_clear: got %b expected 0", error);
      end
      step();
      step();
      src_addr = 32'h0000_0100;
      dst_addr = 32'h2000_00E0;
      length   = 9'd5;
      start    = 1'b1;
      step();
      start    = 1'b0;
      wait_done(4, 40, c);
      tests_run++;
      if (c != 8) begin
         tests_failed++;
         $display("[TB] FAIL b2b_done_cycle: got %0d expected 8", c);
      end
      tests_run++;
      if (addr_log[base] !== 32'hFFFF_FFFC || addr_log[base+2] !== 32'h0000_0000) begin
         tests_failed++;
         $display("[TB] FAIL b2b_wrap_addr: got %h %h expected fffffffc 00000000",
                  addr_log[base], addr_log[base+2]);
      end
      tests_run++;
      if (mem[152] !== 32'h00FF_00AF || mem[153] !== 32'h0000_00A0) begin
         tests_failed++;
         $display("[TB] FAIL b2b_data: got %h %h expected 00ff00af 000000a0", mem[152], mem[153]);
      end
      repeat (4) step();
      tests_run++;
      if (busy !== 1'b0 || n_addr - base != 4) begin
         tests_failed++;
         $display("[TB] FAIL b2b_ignored_start: busy %b addrs %0d expected 0 4", busy, n_addr - base);
      end
   endtask

   task automatic test_reset_mid_copy();
      int c, d0;
      d0 = done_cnt;
      start_copy(32'h0000_0100, 32'h2000_0080, 9'd3);
      repeat (3) step();
      #1 HRESETn = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, error, bus.HWRITE} !== 4'b0000 || bus.HTRANS !== TRANS_IDLE) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_ctrl: busy/done/error/HWRITE %b HTRANS %b expected 0000 00",
                  {busy, done, error, bus.HWRITE}, bus.HTRANS);
      end
      tests_run++;
      if (bus.HADDR !== 32'h0 || bus.HWDATA !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_bus: HADDR/HWDATA got %h/%h expected 0/0", bus.HADDR, bus.HWDATA);
      end
      step();
      step();
      HRESETn = 1'b1;
      step();
      tests_run++;
      if (done_cnt != d0 || wr_flag[160] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_abort: pulses %0d word0_written %b expected 0 0",
                  done_cnt - d0, wr_flag[160]);
      end
      start_copy(32'h0000_0108, 32'h2000_00A0, 9'd2);
      wait_done(1, 40, c);
      tests_run++;
      if (c != 8 || mem[168] !== 32'hA2 || mem[169] !== 32'hA3) begin
         tests_failed++;
         $display("[TB] FAIL rst_mid_recopy: cycle %0d data %h %h expected 8 a2 a3",
                  c, mem[168], mem[169]);
      end
      step();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, %0d tests run", tests_run);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      HRESETn  = 1'b0;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      length   = '0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_length_zero();
      test_error_write();
      test_back_to_back();
      test_reset_mid_copy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
